cla_seq_add_ctrl: RTL

Multi-cycle sequencer that computes a WIDTH-bit addition by reusing one 4-bit carry-look-ahead slice over WIDTH/4 consecutive cycles, least-significant nibble first. A per-request count `approx_k` selects how many low nibbles use the approximate slice (`carry_look_ahead_4bit_app`), whose carry-out ignores its carry-in; the remaining nibbles use the exact slice (`carry_look_ahead_4bit_acc`). The block sits between the CNN accumulator and its operand source. It trades latency for area, and accuracy for power, under valid/ready flow control.

---
 rtl/cla_seq_add_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/cla_seq_add_ctrl.sv
// Sequential WIDTH-bit adder reusing one 4-bit CLA slice, LSB nibble first.
// Define CLA_SEQ_APPROX_EN to enable approximate carries on the low approx_k nibbles.
module carry_look_ahead_4bit_acc (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_s    = w_p ^ w_c;
  assign o_cout = w_g[3] | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (&w_p & i_cin);
endmodule

module carry_look_ahead_4bit_app (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

  // Sum still uses carry-in; only the carry-out drops the propagate-all term.
  assign o_s    = w_p ^ w_c;
  assign o_cout = w_g[3] | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
endmodule

module cla_seq_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           cin,
  input  logic [$clog2(WIDTH/4+1)-1:0]   approx_k,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               sum,
  output logic                           cout,
  output logic                           busy
);
  localparam int N   = WIDTH / 4;
  localparam int K_W = $clog2(N + 1);
  localparam int I_W = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_cout;
  logic [I_W-1:0]   r_i;

  logic [3:0]       w_an;
  logic [3:0]       w_bn;
  logic [3:0]       w_s;
  logic             w_co_acc;
  logic             w_co;

  assign w_an = r_a[{r_i, 2'b00} +: 4];
  assign w_bn = r_b[{r_i, 2'b00} +: 4];

  carry_look_ahead_4bit_acc u_acc (
    .i_a    (w_an),
    .i_b    (w_bn),
    .i_cin  (r_c),
    .o_s    (w_s),
    .o_cout (w_co_acc)
  );

`ifdef CLA_SEQ_APPROX_EN
  logic [K_W-1:0] r_k;
  logic [K_W-1:0] w_k_clamp;
  logic [3:0]     w_unused_app_s;
  logic           w_co_app;

  assign w_k_clamp = (approx_k > K_W'(N)) ? K_W'(N) : approx_k;

  carry_look_ahead_4bit_app u_app (
    .i_a    (w_an),
    .i_b    (w_bn),
    .i_cin  (r_c),
    .o_s    (w_unused_app_s),
    .o_cout (w_co_app)
  );

  assign w_co = (K_W'(r_i) < r_k) ? w_co_app : w_co_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k <= '0;
    end else if (r_state == S_IDLE && in_valid) begin
      r_k <= w_k_clamp;
    end
  end
`else
  logic w_unused_k;

  assign w_unused_k = ^approx_k;
  assign w_co       = w_co_acc;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_i     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= cin;
            r_i     <= '0;
            r_sum   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[{r_i, 2'b00} +: 4] <= w_s;
          r_c <= w_co;
          r_i <= r_i + 1'b1;
          if (r_i == I_W'(N - 1)) begin
            r_cout  <= w_co;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) & ~rst;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;
endmodule
